// File: rtl/scaler_pkg.sv
// Shared types and constants for the RGB video downscaler.
package scaler_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS     = 2'b00,
        MODE_HALF       = 2'b01,
        MODE_THIRD      = 2'b10,
        MODE_BYPASS_ALT = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        METH_DECIMATE     = 2'b00,
        METH_AVERAGE      = 2'b01,
        METH_DECIMATE_ALT = 2'b10,
        METH_DECIMATE_AL3 = 2'b11
    } method_e;

    // sum/9 is computed as (sum * 7282 + 32768) >> 16
    localparam int unsigned RECIP9       = 7282;
    localparam int unsigned RECIP9_SHIFT = 16;
    localparam int unsigned RND_DIV9     = 32768;

    // sum/4 is computed as (sum + 2) >> 2
    localparam int unsigned RND_DIV4     = 2;
    localparam int unsigned DIV4_SHIFT   = 2;

    // Guard bits so a 3x3 sum of full-scale pixels fits
    localparam int ACC_GUARD = 4;

    function automatic int acc_width(input int rgb_width);
        return rgb_width + ACC_GUARD;
    endfunction

endpackage

// File: rtl/scaler_linebuf.sv
// Per-output-column accumulator store: one shared read/write address,
// synchronous write, combinational read, cleared by reset.
module scaler_linebuf #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 42,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // Next array contents: only the addressed entry changes on a write
    always_comb begin
        mem_d = mem_q;
        if (i_we && (int'(i_addr) < DEPTH)) begin
            mem_d[i_addr] = i_wdata;
        end
    end

    // Array storage, cleared on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign o_rdata = (int'(i_addr) < DEPTH) ? mem_q[i_addr] : '0;

endmodule

// File: rtl/rgb_video_scaler.sv
// RGB raster downscaler: bypass, 1/2 or 1/3 in both axes by decimation
// or box averaging. Syncs and scaled pixels leave one clock after input.
module rgb_video_scaler
    import scaler_pkg::*;
#(
    parameter int   HACT      = 9,
    parameter int   VACT      = 9,
    parameter int   RGB_WIDTH = 10,
    parameter logic VSYNC_POL = 1'b0,
    parameter logic HSYNC_POL = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           i_mode,
    input  logic [1:0]           i_method,
    input  logic                 i_vsync,
    input  logic                 i_hsync,
    input  logic                 i_de,
    input  logic [RGB_WIDTH-1:0] i_r_data,
    input  logic [RGB_WIDTH-1:0] i_g_data,
    input  logic [RGB_WIDTH-1:0] i_b_data,
    output logic                 o_vsync,
    output logic                 o_hsync,
    output logic                 o_de_scaled,
    output logic [RGB_WIDTH-1:0] o_r_scaled,
    output logic [RGB_WIDTH-1:0] o_g_scaled,
    output logic [RGB_WIDTH-1:0] o_b_scaled
);

    localparam int ACC_W = acc_width(RGB_WIDTH);
    localparam int BUF_D = HACT / 2;
    localparam int AW    = (BUF_D > 1) ? $clog2(BUF_D) : 1;
    localparam int CW    = $clog2(HACT + 1);
    localparam int RW    = $clog2(VACT + 1);
    localparam logic [CW-1:0] HACT_C = CW'(HACT);
    localparam logic [RW-1:0] VACT_C = RW'(VACT);

    function automatic logic [RGB_WIDTH-1:0] rnd_div4(input logic [ACC_W-1:0] s);
        return RGB_WIDTH'(({1'b0, s} + (ACC_W+1)'(RND_DIV4)) >> DIV4_SHIFT);
    endfunction

    function automatic logic [RGB_WIDTH-1:0] rnd_div9(input logic [ACC_W-1:0] s);
        return RGB_WIDTH'((32'(s) * 32'(RECIP9) + 32'(RND_DIV9)) >> RECIP9_SHIFT);
    endfunction

    // Control state
    mode_e          mode_q, mode_d;
    method_e        method_q, method_d;
    logic           vs_act_q, vs_act_d;
    logic           de_q, de_d;
    logic           frame_ok_q, frame_ok_d;
    logic [1:0]     cx_q, cx_d, ry_q, ry_d;
    logic [CW-1:0]  bx_q, bx_d;
    logic [RW-1:0]  by_q, by_d;

    // Datapath state
    logic [ACC_W-1:0]     hsum_q [3];
    logic [ACC_W-1:0]     hsum_d [3];
    logic [RGB_WIDTH-1:0] o_pix_q [3];
    logic [RGB_WIDTH-1:0] o_pix_d [3];
    logic                 o_vs_q, o_vs_d, o_hs_q, o_hs_d, o_de_q, o_de_d;

    // Combinational helpers
    logic [RGB_WIDTH-1:0] pix [3];
    logic [ACC_W-1:0]     pix_ext [3];
    logic [ACC_W-1:0]     hsum_cur [3];
    logic [ACC_W-1:0]     buf_rd [3];
    logic [ACC_W-1:0]     vsum [3];
    logic [3*ACC_W-1:0]   buf_rdata, buf_wdata;
    logic                 buf_we;
    logic [1:0]           n;
    logic [CW-1:0]        nbx, cur_bx;
    logic [RW-1:0]        nby;
    logic [1:0]           cur_cx;
    logic                 avg, vs_rise, de_rise, de_fall;
    logic                 last_cx, last_ry, in_blk, pix_ok, blk_done;

    assign vs_act_d = i_vsync ^ VSYNC_POL;
    assign vs_rise  = vs_act_d && !vs_act_q;
    assign de_d     = i_de;
    assign de_rise  = i_de && !de_q;
    assign de_fall  = !i_de && de_q;
    assign avg      = (method_q == METH_AVERAGE);
    assign o_vs_d   = i_vsync;
    assign o_hs_d   = i_hsync;

    // Decode the latched mode into block size and output geometry
    always_comb begin
        n   = 2'd1;
        nbx = HACT_C;
        nby = VACT_C;
        case (mode_q)
            MODE_HALF:  begin n = 2'd2; nbx = CW'(HACT / 2); nby = RW'(VACT / 2); end
            MODE_THIRD: begin n = 2'd3; nbx = CW'(HACT / 3); nby = RW'(VACT / 3); end
            default:    ;
        endcase
    end

    // A de rising edge places the current pixel at column zero
    assign cur_cx   = de_rise ? 2'd0 : cx_q;
    assign cur_bx   = de_rise ? '0 : bx_q;
    assign last_cx  = (cur_cx == n - 2'd1);
    assign last_ry  = (ry_q == n - 2'd1);
    assign in_blk   = (cur_bx < nbx) && (by_q < nby);
    assign pix_ok   = i_de && frame_ok_q && !vs_rise;
    assign blk_done = pix_ok && in_blk && last_cx && last_ry;
    assign buf_we   = pix_ok && in_blk && (n != 2'd1) &&
                      (avg ? last_cx : (cur_cx == 2'd0 && ry_q == 2'd0));

    // Mode latch at vsync, frame qualifier, and mod-N column/row counters
    always_comb begin
        mode_d     = mode_q;
        method_d   = method_q;
        frame_ok_d = frame_ok_q;
        cx_d       = cx_q;
        bx_d       = bx_q;
        ry_d       = ry_q;
        by_d       = by_q;
        if (vs_rise) begin
            mode_d     = mode_e'(i_mode);
            method_d   = method_e'(i_method);
            frame_ok_d = 1'b1;
            cx_d       = '0;
            bx_d       = '0;
            ry_d       = '0;
            by_d       = '0;
        end else begin
            if (i_de) begin
                if (last_cx) begin
                    cx_d = '0;
                    bx_d = (cur_bx < HACT_C) ? cur_bx + CW'(1) : cur_bx;
                end else begin
                    cx_d = cur_cx + 2'd1;
                    bx_d = cur_bx;
                end
            end
            if (de_fall) begin
                if (last_ry) begin
                    ry_d = '0;
                    by_d = (by_q < VACT_C) ? by_q + RW'(1) : by_q;
                end else begin
                    ry_d = ry_q + 2'd1;
                end
            end
        end
    end

    // Per-channel horizontal and vertical partial sums, buffer write data
    always_comb begin
        pix[0]    = i_r_data;
        pix[1]    = i_g_data;
        pix[2]    = i_b_data;
        buf_wdata = '0;
        for (int c = 0; c < 3; c++) begin
            pix_ext[c]  = ACC_W'(pix[c]);
            hsum_cur[c] = (cur_cx == 2'd0) ? pix_ext[c] : hsum_q[c] + pix_ext[c];
            hsum_d[c]   = i_de ? hsum_cur[c] : hsum_q[c];
            buf_rd[c]   = buf_rdata[(2-c)*ACC_W +: ACC_W];
            // First line of a block row starts the column sum afresh
            vsum[c]     = (ry_q == 2'd0) ? hsum_cur[c] : buf_rd[c] + hsum_cur[c];
            buf_wdata[(2-c)*ACC_W +: ACC_W] = avg ? vsum[c] : pix_ext[c];
        end
    end

    // Output pixel selection; data holds between strobes
    always_comb begin
        o_de_d = 1'b0;
        for (int c = 0; c < 3; c++) begin
            o_pix_d[c] = o_pix_q[c];
        end
        if (n == 2'd1) begin
            if (pix_ok) begin
                o_de_d = 1'b1;
                for (int c = 0; c < 3; c++) begin
                    o_pix_d[c] = pix[c];
                end
            end
        end else if (blk_done) begin
            o_de_d = 1'b1;
            for (int c = 0; c < 3; c++) begin
                if (!avg) begin
                    o_pix_d[c] = buf_rd[c][RGB_WIDTH-1:0];
                end else if (n == 2'd2) begin
                    o_pix_d[c] = rnd_div4(vsum[c]);
                end else begin
                    o_pix_d[c] = rnd_div9(vsum[c]);
                end
            end
        end
    end

    scaler_linebuf #(
        .DEPTH (BUF_D),
        .WIDTH (3 * ACC_W),
        .AW    (AW)
    ) u_linebuf (
        .clk     (clk),
        .rst     (rst),
        .i_we    (buf_we),
        .i_addr  (cur_bx[AW-1:0]),
        .i_wdata (buf_wdata),
        .o_rdata (buf_rdata)
    );

    // Register all state; reset drives syncs to their inactive level
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= MODE_BYPASS;
            method_q   <= METH_DECIMATE;
            vs_act_q   <= 1'b0;
            de_q       <= 1'b0;
            frame_ok_q <= 1'b0;
            cx_q       <= '0;
            bx_q       <= '0;
            ry_q       <= '0;
            by_q       <= '0;
            for (int c = 0; c < 3; c++) begin
                hsum_q[c]  <= '0;
                o_pix_q[c] <= '0;
            end
            o_vs_q     <= VSYNC_POL;
            o_hs_q     <= HSYNC_POL;
            o_de_q     <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            method_q   <= method_d;
            vs_act_q   <= vs_act_d;
            de_q       <= de_d;
            frame_ok_q <= frame_ok_d;
            cx_q       <= cx_d;
            bx_q       <= bx_d;
            ry_q       <= ry_d;
            by_q       <= by_d;
            for (int c = 0; c < 3; c++) begin
                hsum_q[c]  <= hsum_d[c];
                o_pix_q[c] <= o_pix_d[c];
            end
            o_vs_q     <= o_vs_d;
            o_hs_q     <= o_hs_d;
            o_de_q     <= o_de_d;
        end
    end

    assign o_vsync     = o_vs_q;
    assign o_hsync     = o_hs_q;
    assign o_de_scaled = o_de_q;
    assign o_r_scaled  = o_pix_q[0];
    assign o_g_scaled  = o_pix_q[1];
    assign o_b_scaled  = o_pix_q[2];

endmodule

// File: tb/tb_rgb_video_scaler.sv
// Self-checking bench for rgb_video_scaler: constant-pattern vector table,
// hand-written ramp / mode-change / reset sequences, and random frames
// compared against a block-level reference model.
module tb_rgb_video_scaler;

    localparam int HACT = 9;
    localparam int VACT = 9;
    localparam int RW   = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    i_mode = '0, i_method = '0;
    logic          i_vsync = 1'b0, i_hsync = 1'b0, i_de = 1'b0;
    logic [RW-1:0] i_r_data = '0, i_g_data = '0, i_b_data = '0;
    logic          o_vsync, o_hsync, o_de_scaled;
    logic [RW-1:0] o_r_scaled, o_g_scaled, o_b_scaled;

    always #5 clk = ~clk;

    rgb_video_scaler #(
        .HACT(HACT), .VACT(VACT), .RGB_WIDTH(RW), .VSYNC_POL(1'b0), .HSYNC_POL(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .i_mode(i_mode), .i_method(i_method),
        .i_vsync(i_vsync), .i_hsync(i_hsync), .i_de(i_de),
        .i_r_data(i_r_data), .i_g_data(i_g_data), .i_b_data(i_b_data),
        .o_vsync(o_vsync), .o_hsync(o_hsync), .o_de_scaled(o_de_scaled),
        .o_r_scaled(o_r_scaled), .o_g_scaled(o_g_scaled), .o_b_scaled(o_b_scaled)
    );

    typedef struct { int r; int g; int b; int cyc; } px_t;
    typedef struct { int mode; int meth; int pat; int val; int exp_cnt; int exp_v; } vec_t;

    px_t  obs[$];
    px_t  exp_q[$];
    px_t  mon_s;
    int   pr[VACT][HACT];
    int   pg[VACT][HACT];
    int   pb[VACT][HACT];
    int   pcyc[VACT][HACT];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic ivs_p = 1'b0, ihs_p = 1'b0, rst_p = 1'b1;
    bit   sync_en = 1'b0;
    vec_t vecs[9];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        ivs_p <= i_vsync;
        ihs_p <= i_hsync;
        rst_p <= rst;
    end

    // Collect strobes and check the one-clock sync delay every cycle
    always @(negedge clk) begin
        if (o_de_scaled === 1'b1) begin
            mon_s.r   = int'(o_r_scaled);
            mon_s.g   = int'(o_g_scaled);
            mon_s.b   = int'(o_b_scaled);
            mon_s.cyc = cyc;
            obs.push_back(mon_s);
        end
        if (sync_en) begin
            chk("vsync_dly", longint'(o_vsync), rst_p ? 0 : longint'(ivs_p));
            chk("hsync_dly", longint'(o_hsync), rst_p ? 0 : longint'(ihs_p));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: actual running required finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 constant, 1 ramp, 2 alternating columns, 3 blocks of 1..9, 4 random
    function automatic void fill(input int kind, input int val);
        for (int r = 0; r < VACT; r++) begin
            for (int c = 0; c < HACT; c++) begin
                case (kind)
                    0: begin pr[r][c] = val; pg[r][c] = val; pb[r][c] = val; end
                    1: begin pr[r][c] = c; pg[r][c] = r; pb[r][c] = c + r; end
                    2: begin pr[r][c] = c % 2; pg[r][c] = c % 2; pb[r][c] = c % 2; end
                    3: begin
                        pr[r][c] = (r % 3) * 3 + (c % 3) + 1;
                        pg[r][c] = pr[r][c];
                        pb[r][c] = pr[r][c];
                    end
                    default: begin
                        pr[r][c] = int'($urandom_range(0, 1023));
                        pg[r][c] = int'($urandom_range(0, 1023));
                        pb[r][c] = int'($urandom_range(0, 1023));
                    end
                endcase
            end
        end
    endfunction

    // Reference: list of output pixels in raster order with expected arrival cycle
    function automatic void build_model(input int mode, input int meth);
        int  n;
        px_t p;
        exp_q.delete();
        n = (mode == 1) ? 2 : (mode == 2) ? 3 : 1;
        if (n == 1) begin
            for (int r = 0; r < VACT; r++)
                for (int c = 0; c < HACT; c++) begin
                    p.r = pr[r][c]; p.g = pg[r][c]; p.b = pb[r][c];
                    p.cyc = pcyc[r][c] + 1;
                    exp_q.push_back(p);
                end
        end else begin
            for (int bi = 0; bi < VACT / n; bi++)
                for (int bj = 0; bj < HACT / n; bj++) begin
                    int sr = 0, sg = 0, sb = 0;
                    for (int di = 0; di < n; di++)
                        for (int dj = 0; dj < n; dj++) begin
                            sr += pr[bi*n+di][bj*n+dj];
                            sg += pg[bi*n+di][bj*n+dj];
                            sb += pb[bi*n+di][bj*n+dj];
                        end
                    if (meth == 1) begin
                        p.r = (sr + (n*n)/2) / (n*n);
                        p.g = (sg + (n*n)/2) / (n*n);
                        p.b = (sb + (n*n)/2) / (n*n);
                    end else begin
                        p.r = pr[bi*n][bj*n]; p.g = pg[bi*n][bj*n]; p.b = pb[bi*n][bj*n];
                    end
                    p.cyc = pcyc[bi*n+n-1][bj*n+n-1] + 1;
                    exp_q.push_back(p);
                end
        end
    endfunction

    function automatic longint pack(input px_t p);
        return (longint'(p.r) << 20) | (longint'(p.g) << 10) | longint'(p.b);
    endfunction

    task automatic compare_frame(input string name);
        chk({name, "_count"}, obs.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            chk($sformatf("%s_rgb[%0d]", name, i), pack(obs[i]), pack(exp_q[i]));
            chk($sformatf("%s_lat[%0d]", name, i), obs[i].cyc, exp_q[i].cyc);
        end
    endtask

    // One frame: vsync, then VACT lines each with hsync, porch, HACT de cycles
    task automatic run_frame(input int mode, input int meth, input int mid_mode,
                             input int rst_row, input int rst_col);
        obs.delete();
        i_mode = 2'(mode); i_method = 2'(meth);
        i_vsync = 1'b1; i_hsync = 1'b0; i_de = 1'b0;
        repeat (3) tick();
        i_vsync = 1'b0;
        repeat (3) tick();
        for (int r = 0; r < VACT; r++) begin
            i_hsync = 1'b1; repeat (2) tick();
            i_hsync = 1'b0; repeat (2) tick();
            if (r == 4) i_mode = 2'(mid_mode);
            for (int c = 0; c < HACT; c++) begin
                i_de = 1'b1;
                i_r_data = RW'(pr[r][c]); i_g_data = RW'(pg[r][c]); i_b_data = RW'(pb[r][c]);
                pcyc[r][c] = cyc;
                if (r == rst_row && c == rst_col) rst = 1'b1;
                if (r == rst_row && c == rst_col + 2) rst = 1'b0;
                tick();
                if (r == rst_row && c == rst_col) begin
                    chk("midrst_de",   o_de_scaled, 0);
                    chk("midrst_rgb",  {o_r_scaled, o_g_scaled, o_b_scaled}, 0);
                    chk("midrst_vs",   o_vsync, 0);
                    chk("midrst_hs",   o_hsync, 0);
                    obs.delete();
                end
            end
            i_de = 1'b0;
            repeat (3) tick();
        end
        repeat (4) tick();
    endtask

    initial begin
        // mode, method, pattern, value, strobes per frame, expected channel value
        vecs[0] = '{1, 1, 0, 1023, 16, 1023};
        vecs[1] = '{1, 1, 0, 1,    16, 1};
        vecs[2] = '{1, 1, 2, 0,    16, 1};
        vecs[3] = '{2, 1, 3, 0,    9,  5};
        vecs[4] = '{2, 1, 0, 1023, 9,  1023};
        vecs[5] = '{3, 0, 0, 7,    81, 7};
        vecs[6] = '{1, 2, 2, 0,    16, 0};
        vecs[7] = '{2, 0, 3, 0,    9,  1};
        vecs[8] = '{1, 3, 0, 5,    16, 5};

        rst = 1'b1;
        repeat (3) tick();
        chk("reset_de",  o_de_scaled, 0);
        chk("reset_rgb", {o_r_scaled, o_g_scaled, o_b_scaled}, 0);
        chk("reset_vs",  o_vsync, 0);
        chk("reset_hs",  o_hsync, 0);
        rst = 1'b0;
        tick();
        sync_en = 1'b1;
        repeat (2) tick();

        // Bypass ramp
        fill(1, 0);
        run_frame(0, 0, 0, -1, -1);
        chk("bypass_count81", obs.size(), 81);
        build_model(0, 0);
        compare_frame("bypass_ramp");

        // Half decimate ramp: output (i,j) carries R=2j, G=2i
        fill(1, 0);
        run_frame(1, 0, 1, -1, -1);
        chk("dec2_count16", obs.size(), 16);
        if (obs.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                chk($sformatf("dec2_r[%0d]", i), obs[i].r, 2 * (i % 4));
                chk($sformatf("dec2_g[%0d]", i), obs[i].g, 2 * (i / 4));
            end
        end
        build_model(1, 0);
        compare_frame("dec2_ramp");

        // Constant-pattern vector table
        for (int v = 0; v < 9; v++) begin
            fill(vecs[v].pat, vecs[v].val);
            run_frame(vecs[v].mode, vecs[v].meth, vecs[v].mode, -1, -1);
            chk($sformatf("vec%0d_count", v), obs.size(), vecs[v].exp_cnt);
            for (int i = 0; i < obs.size(); i++) begin
                chk($sformatf("vec%0d_px[%0d]", v, i), pack(obs[i]),
                    (longint'(vecs[v].exp_v) << 20) | (longint'(vecs[v].exp_v) << 10) |
                    longint'(vecs[v].exp_v));
            end
        end

        // Mode request changes mid-frame: takes effect only at the next vsync
        fill(1, 0);
        run_frame(1, 0, 2, -1, -1);
        chk("toggle_cur_count16", obs.size(), 16);
        build_model(1, 0);
        compare_frame("toggle_cur");
        fill(4, 0);
        run_frame(2, 0, 2, -1, -1);
        chk("toggle_next_count9", obs.size(), 9);
        build_model(2, 0);
        compare_frame("toggle_next");

        // Reset mid-line: partial frame discarded, next frame correct
        fill(4, 0);
        run_frame(1, 1, 1, 4, 3);
        chk("midrst_no_strobe", obs.size(), 0);
        fill(4, 0);
        run_frame(1, 1, 1, -1, -1);
        build_model(1, 1);
        compare_frame("post_rst");

        // Random frames
        for (int f = 0; f < 6; f++) begin
            int m, t;
            m = int'($urandom_range(0, 3));
            t = int'($urandom_range(0, 3));
            fill(4, 0);
            run_frame(m, t, m, -1, -1);
            build_model(m, (t == 1) ? 1 : 0);
            compare_frame($sformatf("rand%0d_m%0d_t%0d", f, m, t));
        end

        sync_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
